// File: rtl/cr_prefix_attach_seq.sv
// Prefix attach sequencer: reads the PHD and then the PFD prefix memories into the
// TLV inserter, holding the input pipe until each requested prefix has been emitted.
//
// state    | meaning
// IDLE     | waiting for frm_start
// PHD_REQ  | PHD requested, waiting for the inserter to emit the header word
// PHD_RD   | reading PHD words 0..N_PHD_WORDS-1 (paused by ob_stall)
// PHD_EOT  | draining the last read, then pulsing pmc_phd_eot
// PHD_WAIT | waiting for the inserter to finish emitting the PHD
// PFD_REQ  | PFD requested, waiting for the inserter to emit the header word
// PFD_RD   | reading PFD words 0..pfd_len (paused by ob_stall)
// PFD_EOT  | draining the last read, then pulsing pmc_pfd_eot
// PFD_WAIT | waiting for the inserter's PFD ack
module cr_prefix_attach_seq #(
  parameter int N_PHD_WORDS = 8,
  parameter int PFD_AW      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cceip_cfg,
  input  logic              phd_en,
  input  logic              pfd_en,
  input  logic [5:0]        pfd_len,
  input  logic              frm_start,
  input  logic              ob_stall,
  input  logic              pti_insert_phd_inwrk,
  input  logic              pti_insert_pfd_inwrk,
  input  logic              pti_insert_pfd_ack,
  output logic              ibp_insert_phd_req,
  output logic              ibp_insert_pfd_req,
  output logic              phd_mem_rd,
  output logic [3:0]        phd_mem_addr,
  output logic              pfd_mem_rd,
  output logic [PFD_AW-1:0] pfd_mem_addr,
  output logic              pmc_phd_dout_valid,
  output logic              pmc_pfd_dout_valid,
  output logic              pmc_phd_eot,
  output logic              pmc_pfd_eot,
  output logic              ibp_hold,
  output logic              seq_ovr_err
);

  // One shared read counter, wide enough for both the PHD index and a 64-word PFD.
  localparam int CW = (PFD_AW > 6) ? PFD_AW : 6;
  localparam logic [CW-1:0] PHD_LAST = CW'(N_PHD_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, PHD_REQ, PHD_RD, PHD_EOT, PHD_WAIT,
    PFD_REQ, PFD_RD, PFD_EOT, PFD_WAIT
  } state_t;

  state_t        st, nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pfd_last;
  logic          pfd_en_q;
  logic [5:0]    pfd_len_q;

  assign pfd_last = CW'(pfd_len_q);

  always_comb begin
    nxt = st;
    case (st)
      IDLE:
        if (frm_start && !cceip_cfg) begin
          if (phd_en)      nxt = PHD_REQ;
          else if (pfd_en) nxt = PFD_REQ;
        end
      PHD_REQ:  if (pti_insert_phd_inwrk) nxt = PHD_RD;
      PHD_RD:   if (!ob_stall && cnt == PHD_LAST) nxt = PHD_EOT;
      // eot waits until the last read has surfaced as dout_valid
      PHD_EOT:  if (!phd_mem_rd && pmc_phd_dout_valid) nxt = PHD_WAIT;
      PHD_WAIT: if (!pti_insert_phd_inwrk) nxt = pfd_en_q ? PFD_REQ : IDLE;
      PFD_REQ:  if (pti_insert_pfd_inwrk) nxt = PFD_RD;
      PFD_RD:   if (!ob_stall && cnt == pfd_last) nxt = PFD_EOT;
      PFD_EOT:  if (!pfd_mem_rd && pmc_pfd_dout_valid) nxt = PFD_WAIT;
      PFD_WAIT: if (pti_insert_pfd_ack) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st                 <= IDLE;
      cnt                <= '0;
      pfd_en_q           <= 1'b0;
      pfd_len_q          <= '0;
      ibp_insert_phd_req <= 1'b0;
      ibp_insert_pfd_req <= 1'b0;
      phd_mem_rd         <= 1'b0;
      phd_mem_addr       <= '0;
      pfd_mem_rd         <= 1'b0;
      pfd_mem_addr       <= '0;
      pmc_phd_dout_valid <= 1'b0;
      pmc_pfd_dout_valid <= 1'b0;
      pmc_phd_eot        <= 1'b0;
      pmc_pfd_eot        <= 1'b0;
      ibp_hold           <= 1'b0;
      seq_ovr_err        <= 1'b0;
    end else begin
      st                 <= nxt;
      ibp_hold           <= (nxt != IDLE);
      ibp_insert_phd_req <= nxt inside {PHD_REQ, PHD_RD, PHD_EOT, PHD_WAIT};
      ibp_insert_pfd_req <= nxt inside {PFD_REQ, PFD_RD, PFD_EOT, PFD_WAIT};
      seq_ovr_err        <= frm_start && (st != IDLE);
      phd_mem_rd         <= 1'b0;
      pfd_mem_rd         <= 1'b0;
      pmc_phd_eot        <= 1'b0;
      pmc_pfd_eot        <= 1'b0;
      pmc_phd_dout_valid <= phd_mem_rd;
      pmc_pfd_dout_valid <= pfd_mem_rd;

      case (st)
        IDLE:
          if (frm_start && !cceip_cfg) begin
            pfd_en_q  <= pfd_en;
            pfd_len_q <= pfd_len;
          end
        PHD_REQ, PFD_REQ: cnt <= '0;
        PHD_RD:
          if (!ob_stall) begin
            phd_mem_rd   <= 1'b1;
            phd_mem_addr <= cnt[3:0];
            cnt          <= cnt + CW'(1);
          end
        PHD_EOT:
          if (nxt == PHD_WAIT) begin
            pmc_phd_eot  <= 1'b1;
            phd_mem_addr <= '0;
          end
        PFD_RD:
          if (!ob_stall) begin
            pfd_mem_rd   <= 1'b1;
            pfd_mem_addr <= cnt[PFD_AW-1:0];
            cnt          <= cnt + CW'(1);
          end
        PFD_EOT:
          if (nxt == PFD_WAIT) begin
            pmc_pfd_eot  <= 1'b1;
            pfd_mem_addr <= '0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cr_prefix_attach_seq.md
CR_PREFIX_ATTACH_SEQ -- requirements
Module: cr_prefix_attach_seq

Interface
REQ-001 Parameter N_PHD_WORDS, default 8: prefix-header words per frame, range 1..16.
REQ-002 Parameter PFD_AW, default 6: PFD memory address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cceip_cfg  in  1  engine in CCEIP mode; 1 suppresses all insertion.
REQ-006 phd_en / pfd_en  in  1 each  enable PHD / PFD insertion for the next frame.
REQ-007 pfd_len  in  6  PFD data words minus one, sampled at frame start.
REQ-008 frm_start  in  1  one-cycle pulse: valid sot DATA_UNK TLV word at the input port.
REQ-009 ob_stall  in  1  output FIFO almost-full; blocks memory reads.
REQ-010 pti_insert_phd_inwrk / pti_insert_pfd_inwrk  in  1 each  TLV inserter busy emitting PHD / PFD.
REQ-011 pti_insert_pfd_ack  in  1  TLV inserter finished the PFD.
REQ-012 ibp_insert_phd_req / ibp_insert_pfd_req  out  1 each  insertion requests to the TLV inserter.
REQ-013 phd_mem_rd  out  1; phd_mem_addr  out  4  PHD memory read strobe and address.
REQ-014 pfd_mem_rd  out  1; pfd_mem_addr  out  PFD_AW  PFD memory read strobe and address.
REQ-015 pmc_phd_dout_valid, pmc_pfd_dout_valid, pmc_phd_eot, pmc_pfd_eot  out  1 each  data-valid and end-of-TLV to the inserter.
REQ-016 ibp_hold  out  1  stalls the input pipe while a prefix is being inserted.
REQ-017 seq_ovr_err  out  1  one-cycle pulse: frm_start received while busy.

Function
REQ-018 FSM states: IDLE, PHD_REQ, PHD_RD, PHD_EOT, PHD_WAIT, PFD_REQ, PFD_RD, PFD_EOT, PFD_WAIT.
REQ-019 In IDLE, frm_start with cceip_cfg=0 goes to PHD_REQ if phd_en=1, else to PFD_REQ if pfd_en=1, else stays in IDLE; pfd_en and pfd_len are latched on the same edge.
REQ-020 frm_start with cceip_cfg=1 leaves the FSM in IDLE and holds all outputs low.
REQ-021 ibp_hold is 1 in every state except IDLE and is registered: it rises the cycle after the accepted frm_start.
REQ-022 ibp_insert_phd_req is 1 in PHD_REQ, PHD_RD, PHD_EOT and PHD_WAIT; ibp_insert_pfd_req is 1 in the four PFD states.
REQ-023 PHD_REQ goes to PHD_RD when pti_insert_phd_inwrk=1, i.e. the header word has been emitted.
REQ-024 In PHD_RD, each cycle with ob_stall=0 asserts phd_mem_rd at the current address, starting at 0 and incrementing by 1; ob_stall=1 deasserts rd and holds the address.
REQ-025 Memory read latency is 1: pmc_*_dout_valid is rd delayed by exactly one cycle.
REQ-026 After the read at address N_PHD_WORDS-1, the FSM moves to PHD_EOT; pmc_phd_eot pulses for one cycle, the cycle after the last dout_valid, never coincident with it.
REQ-027 PHD_WAIT waits for pti_insert_phd_inwrk=0, then goes to PFD_REQ if latched pfd_en=1, else to IDLE.
REQ-028 The PFD states behave like the PHD states, except:
  - reads cover addresses 0..pfd_len inclusive;
  - PFD_WAIT exits to IDLE on pti_insert_pfd_ack=1.
REQ-029 pfd_len=0 gives exactly one PFD data word; pfd_len=63 gives 64 words; the address never wraps.
REQ-030 frm_start in any non-IDLE state is ignored and pulses seq_ovr_err the next cycle.
REQ-031 All outputs are registered; the read address resets to 0 on entry to each *_RD state.
REQ-032 Changes to cceip_cfg, phd_en, pfd_en or pfd_len while not in IDLE have no effect on the frame in progress.

Reset
REQ-033 rst=1 at any clock edge forces IDLE, address counters 0, and every output 0 on the next cycle, including mid-frame; no eot pulse is emitted for the aborted frame.
REQ-034 The first frm_start is accepted in the first cycle after rst deasserts.

Verification
REQ-035 N_PHD_WORDS=8, phd_en=1, pfd_en=0, frm_start, inwrk rises 2 cycles later with no stall -> 8 rd pulses at addr 0..7, 8 dout_valid pulses, 1 phd_eot, ibp_hold drops after inwrk falls.
REQ-036 phd_en=1, pfd_en=1, pfd_len=3 -> full PHD sequence, then PFD req, 4 pfd reads at addr 0..3, pfd_eot, exit to IDLE on pfd_ack.
REQ-037 ob_stall=1 for 3 cycles during PHD_RD at address 4 -> no rd for 3 cycles, address held at 4, total rd count still 8.
REQ-038 frm_start during PFD_RD -> seq_ovr_err pulses once; current frame completes unaltered.
REQ-039 cceip_cfg=1, frm_start -> all outputs stay 0; phd_en=pfd_en=0 -> ibp_hold stays 0.
REQ-040 rst during PHD_RD at address 5 -> next cycle all outputs 0, FSM in IDLE; next frm_start restarts at address 0.
